branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/dlx_pkg.sv | 30 +++
 rtl/branch_ctrl_if.sv | 44 ++++
 rtl/link_buf.sv | 31 +++
 rtl/branch_ctrl.sv | 153 +++++++++++++++
 tb/tb_branch_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX control-transfer definitions: opcodes, link register and the
// branch controller state encoding.
package dlx_pkg;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;
    localparam logic [5:0] OP_JR   = 6'h12;
    localparam logic [5:0] OP_JALR = 6'h13;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic {
        RUN      = 1'b0,
        HAZ_WAIT = 1'b1
    } state_t;

    typedef logic [1:0] cnt_t;

    function automatic logic is_rs_reader(input logic [5:0] opcode);
        return (opcode == OP_BEQZ) || (opcode == OP_BNEZ) ||
               (opcode == OP_JR)   || (opcode == OP_JALR);
    endfunction

    function automatic logic is_linker(input logic [5:0] opcode);
        return (opcode == OP_JAL) || (opcode == OP_JALR);
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// ID-stage branch control bundle: pipeline-side hazard/branch inputs and the
// stall, redirect and link-write controls returned by branch_ctrl.
interface branch_ctrl_if;

    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_take;
    logic [31:0] id_target;
    logic [31:0] id_pc_plus_four;
    logic        ex_regwrite;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        mem_is_load;
    logic [4:0]  mem_rd;
    logic        wb_we;

    logic        stall;
    logic        id_ex_bubble;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        if_id_flush;
    logic        link_we;
    logic [31:0] link_data;
    logic        link_pending;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_take, id_target,
               id_pc_plus_four, ex_regwrite, ex_is_load, ex_rd,
               mem_is_load, mem_rd, wb_we,
        input  stall, id_ex_bubble, pc_sel, pc_target, if_id_flush,
               link_we, link_data, link_pending
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_take, id_target,
               id_pc_plus_four, ex_regwrite, ex_is_load, ex_rd,
               mem_is_load, mem_rd, wb_we,
        output stall, id_ex_bubble, pc_sel, pc_target, if_id_flush,
               link_we, link_data, link_pending
    );

endinterface

// File: rtl/link_buf.sv
// One-entry holding buffer for a link (r31) value that could not be written
// because the regfile write port was busy.
module link_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        drain,
    output logic        full,
    output logic [31:0] data
);

    // Load wins over drain so a drain and a new linker in the same cycle
    // leave the buffer occupied with the newer value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            // NOTE: the data register is reset as well, so a value buffered
            // before reset can never reappear on link_data afterwards.
            data <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments for all registered state so every
            // flop samples pre-edge values regardless of statement order.
            full <= 1'b1;
            data <= load_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch controller: load-use stall sequencing, taken-branch
// redirect/flush, and r31 link writes arbitrated against the WB write port.
module branch_ctrl
    import dlx_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    branch_ctrl_if.slave  bus
);

    state_t      state, state_next;
    cnt_t        cnt, cnt_next;
    cnt_t        hazard_cnt;
    logic        rs_reader;
    logic        linker;
    logic        link_stall;
    logic        buf_full;
    logic        buf_drain;
    logic        buf_load;
    logic [31:0] buf_data;

    assign rs_reader = is_rs_reader(bus.id_opcode);
    assign linker    = is_linker(bus.id_opcode);

    // Cycles the rs operand is still unavailable; r0 never creates a hazard.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        hazard_cnt = '0;
        if (rs_reader && (bus.id_rs != '0)) begin
            if (bus.ex_regwrite && bus.ex_is_load && (bus.ex_rd == bus.id_rs))
                hazard_cnt = 2'd2;
            else if (bus.ex_regwrite && (bus.ex_rd == bus.id_rs))
                hazard_cnt = 2'd1;
            else if (bus.mem_is_load && (bus.mem_rd == bus.id_rs))
                hazard_cnt = 2'd1;
        end
    end

    // While a link value is buffered, r31 readers must wait for it, and a
    // second linker cannot be accepted until the buffer can take it.
    assign link_stall = bus.id_valid && buf_full &&
                        ((bus.id_rs == LINK_REG) || (bus.id_rt == LINK_REG) ||
                         (linker && bus.id_take && bus.wb_we));

    assign buf_drain = buf_full && !bus.wb_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The detection cycle in RUN is already the first stall, so cnt holds the
    // stall cycles still owed and HAZ_WAIT covers only hazard_cnt-1 cycles.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RUN: begin
                if (bus.id_valid && (hazard_cnt != '0)) begin
                    cnt_next   = hazard_cnt - 2'd1;
                    state_next = (hazard_cnt > 2'd1) ? HAZ_WAIT : RUN;
                end
            end
            HAZ_WAIT: begin
                cnt_next = cnt - 2'd1;
                if (cnt == 2'd1)
                    state_next = RUN;
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        bus.stall        = 1'b0;
        bus.id_ex_bubble = 1'b0;
        bus.pc_sel       = 1'b0;
        bus.pc_target    = '0;
        bus.if_id_flush  = 1'b0;
        bus.link_we      = 1'b0;
        bus.link_data    = '0;
        buf_load         = 1'b0;

        // A buffered link drains whenever the write port is free, even while
        // ID is stalled or empty.
        if (buf_drain) begin
            bus.link_we   = 1'b1;
            bus.link_data = buf_data;
        end

        case (state)
            HAZ_WAIT: begin
                bus.stall        = 1'b1;
                bus.id_ex_bubble = 1'b1;
            end
            default: begin
                if (bus.id_valid) begin
                    if ((hazard_cnt != '0) || link_stall) begin
                        bus.stall        = 1'b1;
                        bus.id_ex_bubble = 1'b1;
                    end else if (bus.id_take) begin
                        bus.pc_sel      = 1'b1;
                        bus.pc_target   = bus.id_target;
                        bus.if_id_flush = 1'b1;
                        // Write the link directly only when the port is free
                        // and nothing older is queued; otherwise buffer it.
                        if (linker) begin
                            if (bus.wb_we || buf_full) begin
                                buf_load = 1'b1;
                            end else begin
                                bus.link_we   = 1'b1;
                                bus.link_data = bus.id_pc_plus_four;
                            end
                        end
                    end
                end
            end
        endcase

        // Outputs are quiet for the whole time reset is held.
        if (!rst_n) begin
            bus.stall        = 1'b0;
            bus.id_ex_bubble = 1'b0;
            bus.pc_sel       = 1'b0;
            bus.pc_target    = '0;
            bus.if_id_flush  = 1'b0;
            bus.link_we      = 1'b0;
            bus.link_data    = '0;
            buf_load         = 1'b0;
        end
    end

    assign bus.link_pending = buf_full;

    link_buf u_link_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .load_data (bus.id_pc_plus_four),
        .drain     (buf_drain),
        .full      (buf_full),
        .data      (buf_data)
    );

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: each cycle's stimulus pushes its expected
// outputs, which are popped and compared on the following falling edge.
module tb_branch_ctrl;
    import dlx_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    branch_ctrl_if bus ();

    branch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        take;
        logic [31:0] target;
        logic [31:0] pc4;
        logic        ex_rw;
        logic        ex_ld;
        logic [4:0]  ex_rd;
        logic        mem_ld;
        logic [4:0]  mem_rd;
        logic        wb_we;
    } stim_t;

    typedef struct {
        string       name;
        logic        stall;
        logic        bubble;
        logic        pc_sel;
        logic [31:0] pc_target;
        logic        flush;
        logic        link_we;
        logic [31:0] link_data;
        logic        link_pending;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, expv);
        end
    endtask

    function automatic stim_t s_idle();
        stim_t s;
        s.valid  = 1'b0; s.op     = '0;   s.rs     = '0; s.rt    = '0;
        s.take   = 1'b0; s.target = '0;   s.pc4    = '0; s.ex_rw = 1'b0;
        s.ex_ld  = 1'b0; s.ex_rd  = '0;   s.mem_ld = 1'b0;
        s.mem_rd = '0;   s.wb_we  = 1'b0;
        return s;
    endfunction

    function automatic stim_t instr(input logic [5:0] op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic take,
                                    input logic [31:0] target, input logic [31:0] pc4,
                                    input logic wb_we);
        stim_t s;
        s = s_idle();
        s.valid = 1'b1; s.op = op; s.rs = rs; s.rt = rt; s.take = take;
        s.target = target; s.pc4 = pc4; s.wb_we = wb_we;
        return s;
    endfunction

    function automatic exp_t e_none(input string name, input logic pend);
        exp_t e;
        e.name = name; e.stall = 1'b0; e.bubble = 1'b0; e.pc_sel = 1'b0;
        e.pc_target = '0; e.flush = 1'b0; e.link_we = 1'b0; e.link_data = '0;
        e.link_pending = pend;
        return e;
    endfunction

    function automatic exp_t e_stall(input string name, input logic pend);
        exp_t e;
        e = e_none(name, pend);
        e.stall = 1'b1; e.bubble = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_take(input string name, input logic [31:0] tgt, input logic pend);
        exp_t e;
        e = e_none(name, pend);
        e.pc_sel = 1'b1; e.pc_target = tgt; e.flush = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_lnk(input exp_t e_in, input logic [31:0] data);
        exp_t e;
        e = e_in;
        e.link_we = 1'b1; e.link_data = data;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        bus.id_valid        = s.valid;
        bus.id_opcode       = s.op;
        bus.id_rs           = s.rs;
        bus.id_rt           = s.rt;
        bus.id_take         = s.take;
        bus.id_target       = s.target;
        bus.id_pc_plus_four = s.pc4;
        bus.ex_regwrite     = s.ex_rw;
        bus.ex_is_load      = s.ex_ld;
        bus.ex_rd           = s.ex_rd;
        bus.mem_is_load     = s.mem_ld;
        bus.mem_rd          = s.mem_rd;
        bus.wb_we           = s.wb_we;
    endtask

    task automatic compare();
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".stall"},        32'(bus.stall),        32'(e.stall));
        check({e.name, ".bubble"},       32'(bus.id_ex_bubble), 32'(e.bubble));
        check({e.name, ".pc_sel"},       32'(bus.pc_sel),       32'(e.pc_sel));
        check({e.name, ".pc_target"},    bus.pc_target,         e.pc_target);
        check({e.name, ".flush"},        32'(bus.if_id_flush),  32'(e.flush));
        check({e.name, ".link_we"},      32'(bus.link_we),      32'(e.link_we));
        check({e.name, ".link_data"},    bus.link_data,         e.link_data);
        check({e.name, ".link_pending"}, 32'(bus.link_pending), 32'(e.link_pending));
    endtask

    // Entered at posedge+1; leaves at the next posedge+1.
    task automatic cycle(input stim_t s, input exp_t e);
        apply(s);
        exp_q.push_back(e);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        exp_q.push_back(e_none(name, 1'b0));
        compare();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;

        apply(s_idle());
        #12;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain branches
        cycle(instr(OP_BEQZ, 5'd3, 5'd4, 1'b1, 32'h100, 32'h10, 1'b0), e_take("beqz_taken", 32'h100, 1'b0));
        cycle(instr(OP_BEQZ, 5'd3, 5'd4, 1'b0, 32'h100, 32'h10, 1'b0), e_none("beqz_not_taken", 1'b0));
        s = instr(OP_BNEZ, 5'd3, 5'd4, 1'b1, 32'h104, 32'h14, 1'b0);
        s.valid = 1'b0;
        cycle(s, e_none("id_invalid", 1'b0));

        // jr behind a load in EX: two stalls, redirect on the third cycle
        s = instr(OP_JR, 5'd5, 5'd0, 1'b1, 32'h200, 32'h20, 1'b0);
        s.ex_rw = 1'b1; s.ex_ld = 1'b1; s.ex_rd = 5'd5;
        cycle(s, e_stall("jr_load_c1", 1'b0));
        s.ex_rw = 1'b0; s.ex_ld = 1'b0; s.ex_rd = '0; s.mem_ld = 1'b1; s.mem_rd = 5'd5;
        cycle(s, e_stall("jr_load_c2", 1'b0));
        s.mem_ld = 1'b0; s.mem_rd = '0;
        cycle(s, e_take("jr_load_c3", 32'h200, 1'b0));

        // bnez behind a load in MEM: one stall
        s = instr(OP_BNEZ, 5'd7, 5'd0, 1'b1, 32'h300, 32'h30, 1'b0);
        s.mem_ld = 1'b1; s.mem_rd = 5'd7;
        cycle(s, e_stall("bnez_mem_c1", 1'b0));
        s.mem_ld = 1'b0; s.mem_rd = '0;
        cycle(s, e_take("bnez_mem_c2", 32'h300, 1'b0));

        // r0 never hazards
        s = instr(OP_BNEZ, 5'd0, 5'd0, 1'b1, 32'h304, 32'h34, 1'b0);
        s.ex_rw = 1'b1; s.ex_ld = 1'b1; s.ex_rd = 5'd0;
        cycle(s, e_take("bnez_r0", 32'h304, 1'b0));

        // ALU result in EX: one stall, then not taken
        s = instr(OP_BEQZ, 5'd9, 5'd0, 1'b0, 32'h308, 32'h38, 1'b0);
        s.ex_rw = 1'b1; s.ex_rd = 5'd9;
        cycle(s, e_stall("beqz_alu_c1", 1'b0));
        s.ex_rw = 1'b0; s.ex_rd = '0;
        cycle(s, e_none("beqz_alu_c2", 1'b0));

        // j does not read rs
        s = instr(OP_J, 5'd9, 5'd0, 1'b1, 32'h340, 32'h3c, 1'b0);
        s.ex_rw = 1'b1; s.ex_ld = 1'b1; s.ex_rd = 5'd9;
        cycle(s, e_take("j_no_rs", 32'h340, 1'b0));

        // Direct link writes with a free port
        cycle(instr(OP_JAL, 5'd0, 5'd0, 1'b1, 32'h400, 32'h20, 1'b0),
              e_lnk(e_take("jal_direct", 32'h400, 1'b0), 32'h20));
        cycle(instr(OP_JALR, 5'd6, 5'd0, 1'b1, 32'h380, 32'h38, 1'b0),
              e_lnk(e_take("jalr_direct", 32'h380, 1'b0), 32'h38));

        // jal while WB owns the port: buffered, drained when wb_we drops
        cycle(instr(OP_JAL, 5'd0, 5'd0, 1'b1, 32'h500, 32'h44, 1'b1), e_take("jal_buf_c1", 32'h500, 1'b0));
        s = s_idle(); s.wb_we = 1'b1;
        cycle(s, e_none("jal_buf_c2", 1'b1));
        s.wb_we = 1'b0;
        cycle(s, e_lnk(e_none("jal_buf_drain", 1'b1), 32'h44));
        cycle(s_idle(), e_none("jal_buf_empty", 1'b0));

        // r31 reader waits for the pending link
        cycle(instr(OP_JAL, 5'd0, 5'd0, 1'b1, 32'h600, 32'h48, 1'b1), e_take("jal_r31_c1", 32'h600, 1'b0));
        s = instr(OP_BEQZ, 5'd2, 5'd31, 1'b1, 32'h700, 32'h70, 1'b1);
        cycle(s, e_stall("r31_c2", 1'b1));
        cycle(s, e_stall("r31_c3", 1'b1));
        s.wb_we = 1'b0;
        cycle(s, e_lnk(e_stall("r31_drain", 1'b1), 32'h48));
        cycle(s, e_take("r31_go", 32'h700, 1'b0));

        // Second jal stalls while port busy, then drain + new latch coincide
        cycle(instr(OP_JAL, 5'd0, 5'd0, 1'b1, 32'h800, 32'h4c, 1'b1), e_take("jal2_c1", 32'h800, 1'b0));
        s = instr(OP_JAL, 5'd0, 5'd0, 1'b1, 32'h880, 32'h50, 1'b1);
        cycle(s, e_stall("jal2_stall", 1'b1));
        s.wb_we = 1'b0;
        cycle(s, e_lnk(e_take("jal2_swap", 32'h880, 1'b1), 32'h4c));
        cycle(s_idle(), e_lnk(e_none("jal2_drain_new", 1'b1), 32'h50));
        cycle(s_idle(), e_none("jal2_empty", 1'b0));

        // Reset during HAZ_WAIT with a link pending
        cycle(instr(OP_JAL, 5'd0, 5'd0, 1'b1, 32'h900, 32'h60, 1'b1), e_take("rst_jal", 32'h900, 1'b0));
        s = instr(OP_JR, 5'd5, 5'd0, 1'b1, 32'ha00, 32'h64, 1'b1);
        s.ex_rw = 1'b1; s.ex_ld = 1'b1; s.ex_rd = 5'd5;
        cycle(s, e_stall("rst_haz_c1", 1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid");
        @(posedge clk);
        #1;
        apply(s_idle());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            cycle(s_idle(), e_none($sformatf("post_rst_idle%0d", i), 1'b0));
        cycle(instr(OP_BEQZ, 5'd3, 5'd0, 1'b1, 32'hb00, 32'hb4, 1'b0), e_take("post_rst_take", 32'hb00, 1'b0));

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
